flush_redirect_ctrl: RTL

- Sequences the pipeline-wide flush and fetch redirect when WB commits an exception or an ertn.
- Replaces the ad-hoc post-exception register-write blocking with an explicit state machine.
- Drives the CSR exception-commit strobe, a held redirect request to IF, and a commit-block signal to WB.
- Holds commit-block until the first refetched instruction enters WB.
- Sits between WB, the CSR file and IF.

---
 rtl/flush_redirect_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/flush_redirect_ctrl.sv
// Flush / fetch-redirect sequencer: on a WB exception or ertn it strobes the CSR
// file, flushes the front of the pipe, redirects IF and blocks WB commits until refetch.
module flush_redirect_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 wb_exc,
    input  logic [5:0]           wb_ecode,
    input  logic [8:0]           wb_esubcode,
    input  logic [31:0]          wb_pc,
    input  logic [31:0]          wb_badvaddr,
    input  logic                 ertn_flush,
    input  logic                 wb_accept,
    input  logic [31:0]          csr_eentry,
    input  logic [31:0]          csr_era,
    input  logic                 redir_ready,
    output logic                 exc_commit,
    output logic [5:0]           exc_ecode,
    output logic [8:0]           exc_esubcode,
    output logic [31:0]          exc_pc,
    output logic [31:0]          exc_badvaddr,
    output logic                 ertn_commit,
    output logic                 flush_out,
    output logic                 redir_valid,
    output logic [31:0]          redir_pc,
    output logic                 commit_block,
    output logic [CNT_WIDTH-1:0] exc_cnt,
    output logic [CNT_WIDTH-1:0] ertn_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REDIR = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          tgt_pc_q, tgt_pc_d;
    logic [CNT_WIDTH-1:0] exc_cnt_q, exc_cnt_d;
    logic [CNT_WIDTH-1:0] ertn_cnt_q, ertn_cnt_d;

    logic in_idle;
    logic exc_ev;
    logic ertn_ev;

    // Events pass straight from WB inputs, so they are also gated by resetn to keep
    // every output quiet while reset is held.
    always_comb begin
        in_idle = resetn && (state_q == IDLE);
        exc_ev  = in_idle && wb_exc;
        ertn_ev = in_idle && ertn_flush && !wb_exc;
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no latch is inferred.
        exc_commit   = exc_ev;
        exc_ecode    = '0;
        exc_esubcode = '0;
        exc_pc       = '0;
        exc_badvaddr = '0;
        ertn_commit  = ertn_ev;
        flush_out    = 1'b0;
        redir_valid  = 1'b0;
        redir_pc     = '0;
        commit_block = 1'b0;
        state_d      = state_q;
        tgt_pc_d     = tgt_pc_q;
        exc_cnt_d    = exc_cnt_q;
        ertn_cnt_d   = ertn_cnt_q;

        if (exc_ev) begin
            exc_ecode    = wb_ecode;
            exc_esubcode = wb_esubcode;
            exc_pc       = wb_pc;
            exc_badvaddr = wb_badvaddr;
        end

        unique case (state_q)
            IDLE: begin
                if (exc_ev || ertn_ev) begin
                    flush_out    = 1'b1;
                    commit_block = 1'b1;
                    state_d      = REDIR;
                    // Target is sampled now, before the CSR update from this commit lands.
                    tgt_pc_d     = exc_ev ? csr_eentry : csr_era;
                end
                if (exc_ev)  exc_cnt_d  = exc_cnt_q + CNT_WIDTH'(1);
                if (ertn_ev) ertn_cnt_d = ertn_cnt_q + CNT_WIDTH'(1);
            end
            REDIR: begin
                redir_valid  = 1'b1;
                redir_pc     = tgt_pc_q;
                flush_out    = 1'b1;
                commit_block = 1'b1;
                if (redir_ready) state_d = DRAIN;
            end
            DRAIN: begin
                commit_block = 1'b1;
                if (wb_accept) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            tgt_pc_q   <= '0;
            exc_cnt_q  <= '0;
            ertn_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tgt_pc_q   <= tgt_pc_d;
            exc_cnt_q  <= exc_cnt_d;
            ertn_cnt_q <= ertn_cnt_d;
        end
    end

    assign exc_cnt  = exc_cnt_q;
    assign ertn_cnt = ertn_cnt_q;

endmodule
